// File: rtl/io_uart_pkg.sv
// ---------------------------------------------------------------------------
// io_uart_pkg
// Shared definitions for the memory-mapped UART: register offsets decoded
// from mem_addr[4:3], STATUS bit positions, serial FSM state encodings, and a
// helper that computes the start-bit re-check delay.
// ---------------------------------------------------------------------------
package io_uart_pkg;

    // Register select values (mem_addr[4:3])
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;

    // STATUS register bit positions
    localparam int STAT_TX_FULL   = 0;
    localparam int STAT_TX_EMPTY  = 1;
    localparam int STAT_RX_EMPTY  = 2;
    localparam int STAT_RX_FULL   = 3;
    localparam int STAT_OVERRUN   = 4;
    localparam int STAT_FRAME_ERR = 5;
    localparam int STAT_TX_BUSY   = 6;
    localparam int STAT_W         = 7;

    // Serial FSM states, shared by the TX and RX engines
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Counter preload so the start bit is re-checked (div+1)/2 clocks after
    // the falling edge is seen; one clock is already spent entering START.
    function automatic logic [15:0] half_bit(input logic [15:0] div);
        logic [16:0] h;
        h = ({1'b0, div} + 17'd1) >> 1;
        return (h == 17'd0) ? 16'd0 : 16'(h - 17'd1);
    endfunction

endpackage

// File: rtl/io_uart_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. Pointers carry one extra bit so
// full and empty are distinguished without a separate counter.
//   push_i/din_i  : write request and data (ignored when full unless popping)
//   pop_i         : read request (ignored when empty)
//   dout_o        : head entry, valid whenever empty_o is low
//   full_o/empty_o: occupancy flags
// DEPTH must be a power of two, minimum 2.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on empty is dropped; a push on full only lands if a pop frees
    // the slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/io_uart.sv
// ---------------------------------------------------------------------------
// io_uart
// Memory-mapped 8N1 UART on the CPU external data bus, with TX/RX byte FIFOs.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   io_sel            : access targets IO space
//   mem_addr/mem_dout : byte address and write data from the CPU
//   mem_dout_write    : one-cycle write strobe
//   io_rstrobe        : one-cycle read strobe
//   mem_din           : registered read data
//   mem_din_ready     : one-cycle completion pulse, one clock after a hit
//   uart_rx/uart_tx   : serial line (rx asynchronous, tx idle high)
// Registers (mem_addr[4:3]): TXDATA, RXDATA, STATUS, BAUDDIV.
// ---------------------------------------------------------------------------
module io_uart
    import io_uart_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'hFFFF_FFFF_FFFF_FF00,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_sel,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_dout,
    input  logic        mem_dout_write,
    input  logic        io_rstrobe,
    output logic [63:0] mem_din,
    output logic        mem_din_ready,
    input  logic        uart_rx,
    output logic        uart_tx
);

    // ---------------- bus decode ----------------
    logic       hit, wr_en, rd_en;
    logic [1:0] reg_sel;

    assign hit     = io_sel & (mem_addr[63:5] == BASE_ADDR[63:5]);
    assign reg_sel = mem_addr[4:3];
    assign wr_en   = hit & mem_dout_write;
    assign rd_en   = hit & io_rstrobe & ~mem_dout_write;   // write wins

    logic unused_bits;
    assign unused_bits = ^{mem_addr[2:0], mem_dout[63:16]};

    // ---------------- FIFOs ----------------
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout, rx_shift_q, rx_shift_d;

    assign tx_push = wr_en & (reg_sel == REG_TXDATA);
    assign rx_pop  = rd_en & (reg_sel == REG_RXDATA) & ~rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .din_i   (mem_dout[7:0]),
        .dout_o  (tx_dout),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .din_i   (rx_shift_d),
        .dout_o  (rx_dout),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // ---------------- register file / bus response ----------------
    logic [63:0] din_q, din_d, rdata;
    logic        ready_q, ready_d;
    logic [15:0] baud_q, baud_d;
    logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic        overrun_set, frame_err_set;
    logic [1:0]  tx_state_q, tx_state_d;
    logic [STAT_W-1:0] status;

    assign status[STAT_TX_FULL]   = tx_full;
    assign status[STAT_TX_EMPTY]  = tx_empty;
    assign status[STAT_RX_EMPTY]  = rx_empty;
    assign status[STAT_RX_FULL]   = rx_full;
    assign status[STAT_OVERRUN]   = overrun_q;
    assign status[STAT_FRAME_ERR] = frame_err_q;
    assign status[STAT_TX_BUSY]   = (tx_state_q != ST_IDLE);

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rdata       = '0;
        din_d       = din_q;
        ready_d     = 1'b0;
        baud_d      = baud_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        case (reg_sel)
            REG_RXDATA:  if (!rx_empty) rdata = {55'd0, 1'b1, rx_dout};
            REG_STATUS:  rdata = {{(64-STAT_W){1'b0}}, status};
            REG_BAUDDIV: rdata = {48'd0, baud_q};
            default:     rdata = '0;
        endcase

        if (wr_en) begin
            ready_d = 1'b1;
            din_d   = '0;
            if (reg_sel == REG_BAUDDIV) baud_d = mem_dout[15:0];
            if (reg_sel == REG_STATUS) begin
                if (mem_dout[STAT_OVERRUN])   overrun_d   = 1'b0;
                if (mem_dout[STAT_FRAME_ERR]) frame_err_d = 1'b0;
            end
        end else if (rd_en) begin
            ready_d = 1'b1;
            din_d   = rdata;
        end

        // A new error in the same cycle as a clear is kept.
        if (overrun_set)   overrun_d   = 1'b1;
        if (frame_err_set) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q       <= '0;
            ready_q     <= 1'b0;
            baud_q      <= DEFAULT_DIV;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            din_q       <= din_d;
            ready_q     <= ready_d;
            baud_q      <= baud_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mem_din       = din_q;
    assign mem_din_ready = ready_q;

    // ---------------- TX engine ----------------
    // The bit counter is reloaded from baud_q only at bit boundaries, so a
    // BAUDDIV write mid-frame changes the length of the next bit onward.
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_line_q, tx_line_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;

        case (tx_state_q)
            ST_IDLE: begin
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                    tx_cnt_d   = baud_q;
                    tx_line_d  = 1'b0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = baud_q;
                    tx_bit_d   = 3'd0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = baud_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: begin // ST_STOP
                if (tx_cnt_q == 16'd0) begin
                    // Chain straight into the next start bit when more data
                    // is queued, so back-to-back bytes have no idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_dout;
                        tx_cnt_d   = baud_q;
                        tx_line_d  = 1'b0;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign uart_tx = tx_line_q;

    // ---------------- RX engine ----------------
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_fall;

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_push       = 1'b0;
        overrun_set   = 1'b0;
        frame_err_set = 1'b0;

        case (rx_state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = half_bit(baud_q);
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_sync_q) begin
                        rx_state_d = ST_IDLE;          // glitch, not a start bit
                    end else begin
                        rx_cnt_d   = baud_q;
                        rx_bit_d   = 3'd0;
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};   // LSB first
                    rx_cnt_d   = baud_q;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: begin // ST_STOP
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = ST_IDLE;
                    if (!rx_sync_q)              frame_err_set = 1'b1;
                    else if (rx_full && !rx_pop) overrun_set   = 1'b1;
                    else                         rx_push       = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_io_uart.sv
// ---------------------------------------------------------------------------
// tb_io_uart
// Directed bench for io_uart: a register-access vector table followed by
// hand-written serial sequences (TX framing, TX FIFO fill, RX receive,
// overrun, framing error, glitch rejection, reset mid-frame).
// ---------------------------------------------------------------------------
module tb_io_uart;

    localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] A_TX = BASE + 64'h00;
    localparam logic [63:0] A_RX = BASE + 64'h08;
    localparam logic [63:0] A_ST = BASE + 64'h10;
    localparam logic [63:0] A_BD = BASE + 64'h18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_sel;
    logic [63:0] mem_addr;
    logic [63:0] mem_dout;
    logic        mem_dout_write;
    logic        io_rstrobe;
    logic [63:0] mem_din;
    logic        mem_din_ready;
    logic        uart_rx;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;

    io_uart dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .io_sel         (io_sel),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .mem_dout_write (mem_dout_write),
        .io_rstrobe     (io_rstrobe),
        .mem_din        (mem_din),
        .mem_din_ready  (mem_din_ready),
        .uart_rx        (uart_rx),
        .uart_tx        (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus access: drive on a negedge, sample the response one cycle later,
    // then sample ready again to confirm it was a single-cycle pulse.
    task automatic bus(input logic wr, input logic rd, input logic sel,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       output logic rdy, output logic [63:0] din, output logic rdy_after);
        @(negedge clk);
        io_sel = sel; mem_addr = addr; mem_dout = wdata;
        mem_dout_write = wr; io_rstrobe = rd;
        @(negedge clk);
        io_sel = 1'b0; mem_dout_write = 1'b0; io_rstrobe = 1'b0;
        rdy = mem_din_ready; din = mem_din;
        @(negedge clk);
        rdy_after = mem_din_ready;
    endtask

    task automatic reg_write(input logic [63:0] addr, input logic [63:0] wdata);
        logic r, ra; logic [63:0] d;
        bus(1'b1, 1'b0, 1'b1, addr, wdata, r, d, ra);
        check("wr_ready", {63'd0, r}, 64'd1);
    endtask

    task automatic reg_read_chk(input string name, input logic [63:0] addr, input logic [63:0] exp);
        logic r, ra; logic [63:0] d;
        bus(1'b0, 1'b1, 1'b1, addr, 64'd0, r, d, ra);
        check({name, "_rdy"}, {63'd0, r}, 64'd1);
        check(name, d, exp);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (div + 1) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Line monitor: decodes frames on uart_tx at mon_div clocks-per-bit - 1.
    logic [7:0] mon_q[$];
    int         mon_div = 3;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                repeat ((mon_div + 1) / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (mon_div + 1) @(negedge clk);
                    b[k] = uart_tx;
                end
                repeat (mon_div + 1) @(negedge clk);
                mon_q.push_back(b);
            end
        end
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic        sel;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_rdy;
        logic        chk_din;
        logic [63:0] exp_din;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic        r, ra;
        logic [63:0] d;
        logic [9:0]  a5_bits;
        int          n;

        // wr rd sel addr wdata exp_rdy chk_din exp_din
        vecs[0]  = '{1'b0, 1'b1, 1'b1, A_ST, 64'd0, 1'b1, 1'b1, 64'h6};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, A_BD, 64'd0, 1'b1, 1'b1, 64'd433};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, A_TX, 64'd0, 1'b1, 1'b1, 64'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, A_RX, 64'd0, 1'b1, 1'b1, 64'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, A_BD, 64'hDEAD_BEEF_0000_1234, 1'b1, 1'b0, 64'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, BASE + 64'h1F, 64'd0, 1'b1, 1'b1, 64'h1234};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FE10, 64'd0, 1'b0, 1'b1, 64'h1234};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, A_ST, 64'd0, 1'b0, 1'b1, 64'h1234};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, A_BD, 64'd3, 1'b1, 1'b0, 64'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, A_BD, 64'd0, 1'b1, 1'b1, 64'd3};
        vecs[10] = '{1'b0, 1'b1, 1'b1, BASE + 64'h13, 64'd0, 1'b1, 1'b1, 64'h6};

        rst_n = 1'b0; io_sel = 1'b0; mem_addr = '0; mem_dout = '0;
        mem_dout_write = 1'b0; io_rstrobe = 1'b0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {63'd0, uart_tx}, 64'd1);
        check("rst_mem_din", mem_din, 64'd0);
        check("rst_ready", {63'd0, mem_din_ready}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- register access table ----
        for (int i = 0; i < 11; i++) begin
            bus(vecs[i].wr, vecs[i].rd, vecs[i].sel, vecs[i].addr, vecs[i].wdata, r, d, ra);
            check($sformatf("vec%0d_rdy", i), {63'd0, r}, {63'd0, vecs[i].exp_rdy});
            if (vecs[i].chk_din) check($sformatf("vec%0d_din", i), d, vecs[i].exp_din);
            if (vecs[i].exp_rdy) check($sformatf("vec%0d_rdy_pulse", i), {63'd0, ra}, 64'd0);
        end
        check("idle_uart_tx", {63'd0, uart_tx}, 64'd1);

        // ---- TX 0xA5 at BAUDDIV=3 ----
        reg_write(A_BD, 64'd3);
        mon_div = 3;
        mon_q.delete();
        a5_bits = {1'b1, 8'hA5, 1'b0};
        reg_write(A_TX, 64'hA5);
        n = 0;
        while (uart_tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", {63'd0, n < 50}, 64'd1);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if (i > 0) @(negedge clk);
                    check($sformatf("tx_a5_clk%0d", i), {63'd0, uart_tx}, {63'd0, a5_bits[i/4]});
                end
            end
            begin
                repeat (10) @(negedge clk);
                reg_read_chk("status_busy", A_ST, 64'h46);
            end
        join
        repeat (2) @(negedge clk);
        reg_read_chk("status_after_tx", A_ST, 64'h6);
        check("mon_a5_count", 64'(mon_q.size()), 64'd1);
        if (mon_q.size() > 0) check("mon_a5_byte", {56'd0, mon_q[0]}, 64'hA5);

        // ---- TX FIFO fill: 18 writes, 17 accepted ----
        reg_write(A_BD, 64'd20);
        mon_div = 20;
        mon_q.delete();
        for (int i = 0; i < 18; i++)
            reg_write(A_TX, (i == 17) ? 64'hEE : 64'(8'h10 + i));
        n = 0;
        while (mon_q.size() < 17 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (400) @(negedge clk);
        check("tx_frame_count", 64'(mon_q.size()), 64'd17);
        for (int i = 0; i < 17; i++)
            if (i < mon_q.size()) check($sformatf("tx_fifo_byte%0d", i), {56'd0, mon_q[i]}, 64'(8'h10 + i));
        reg_read_chk("status_tx_drained", A_ST, 64'h6);

        // ---- RX single frame at BAUDDIV=7 ----
        reg_write(A_BD, 64'd7);
        drive_rx(8'h3C, 1'b1, 7);
        reg_read_chk("rx_3c", A_RX, 64'h13C);
        reg_read_chk("rx_empty_read", A_RX, 64'h0);
        reg_read_chk("status_rx_empty", A_ST, 64'h6);

        // ---- RX overrun: 17 frames, no reads ----
        for (int i = 0; i < 17; i++) drive_rx(8'(8'h40 + i), 1'b1, 7);
        reg_read_chk("status_overrun", A_ST, 64'h1A);
        for (int i = 0; i < 16; i++)
            reg_read_chk($sformatf("rx_ovr_byte%0d", i), A_RX, 64'h100 | 64'(8'h40 + i));
        reg_read_chk("status_ovr_drained", A_ST, 64'h16);
        reg_write(A_ST, 64'h10);
        reg_read_chk("status_ovr_cleared", A_ST, 64'h6);

        // ---- framing error, then a 1-clock glitch ----
        drive_rx(8'h55, 1'b0, 7);
        reg_read_chk("status_frame_err", A_ST, 64'h26);
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (50) @(negedge clk);
        reg_read_chk("status_after_glitch", A_ST, 64'h26);
        reg_read_chk("rx_after_glitch", A_RX, 64'h0);
        reg_write(A_ST, 64'h20);
        reg_read_chk("status_fe_cleared", A_ST, 64'h6);
        drive_rx(8'h81, 1'b1, 7);
        reg_read_chk("rx_81", A_RX, 64'h181);

        // ---- reset mid-frame ----
        reg_write(A_TX, 64'h00);
        n = 0;
        while (uart_tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_before_reset", {63'd0, n < 50}, 64'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_midframe_tx", {63'd0, uart_tx}, 64'd1);
        @(negedge clk) rst_n = 1'b1;
        reg_read_chk("baud_after_reset", A_BD, 64'd433);
        reg_read_chk("status_after_reset", A_ST, 64'h6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
